// File: rtl/connect4_move_input.sv
`timescale 1ns/1ps
// Connect-4 move input: cursor control with auto-repeat and a valid/ready
// column-drop request toward the game engine.
module connect4_move_input #(
  parameter int unsigned NUM_COLS     = 7,
  parameter int unsigned COL_W        = 3,
  parameter int unsigned CNT_W        = 25,
  parameter int unsigned REPEAT_DELAY = 25000000,
  parameter int unsigned REPEAT_RATE  = 5000000
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                btn_left,
  input  logic                btn_right,
  input  logic                btn_drop,
  input  logic                enable,
  input  logic [NUM_COLS-1:0] col_full,
  input  logic                move_ready,
  output logic [COL_W-1:0]    cursor_col,
  output logic                move_valid,
  output logic [COL_W-1:0]    move_col,
  output logic                reject_pulse,
  output logic                busy
);

  localparam logic [COL_W-1:0] COL_RESET  = COL_W'(NUM_COLS / 2);
  localparam logic [COL_W-1:0] COL_LAST   = COL_W'(NUM_COLS - 1);
  localparam logic [CNT_W-1:0] CNT_FIRE   = CNT_W'(REPEAT_DELAY - 1);
  // Reloading here leaves exactly REPEAT_RATE increments to the next fire.
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(REPEAT_DELAY - REPEAT_RATE);

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         btn_q;   // {drop, right, left}, sampled levels
  logic [2:0]         prev_q;  // one cycle older copy of btn_q
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [COL_W-1:0]   cursor_d;
  logic [COL_W-1:0]   move_col_d;
  logic               move_valid_d;
  logic               reject_d;
  logic               busy_d;
  logic               rep_step;
  logic               rise_left, rise_right, rise_drop, hold_one;

  assign rise_left  = btn_q[0] & ~prev_q[0];
  assign rise_right = btn_q[1] & ~prev_q[1];
  assign rise_drop  = btn_q[2] & ~prev_q[2];
  assign hold_one   = btn_q[0] ^ btn_q[1];

  function automatic logic [COL_W-1:0] col_dec(input logic [COL_W-1:0] c);
    return (c == '0) ? COL_LAST : c - COL_W'(1);
  endfunction

  function automatic logic [COL_W-1:0] col_inc(input logic [COL_W-1:0] c);
    return (c == COL_LAST) ? '0 : c + COL_W'(1);
  endfunction

  // FSM state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state, cursor, repeat counter and request logic
  always_comb begin
    state_d      = state_q;
    cursor_d     = cursor_col;
    cnt_d        = cnt_q;
    move_valid_d = move_valid;
    move_col_d   = move_col;
    reject_d     = 1'b0;
    rep_step     = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d        = '0;
        move_valid_d = 1'b0;
        if (enable) begin
          if (hold_one && !(rise_left || rise_right)) begin
            if (cnt_q == CNT_FIRE) begin
              rep_step = 1'b1;
              cnt_d    = CNT_RELOAD;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          if (rise_drop) begin
            if (col_full[cursor_col]) begin
              reject_d = 1'b1;
            end else begin
              move_col_d   = cursor_col;
              move_valid_d = 1'b1;
              state_d      = REQ;
            end
          end else if (rise_left && !rise_right) begin
            cursor_d = col_dec(cursor_col);
          end else if (rise_right && !rise_left) begin
            cursor_d = col_inc(cursor_col);
          end else if (rep_step) begin
            cursor_d = btn_q[0] ? col_dec(cursor_col) : col_inc(cursor_col);
          end
        end
      end
      REQ: begin
        cnt_d = '0;
        if (move_ready) begin
          move_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == REQ);
  end

  // Datapath and output registers; history resets high to ignore held buttons
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      btn_q        <= 3'b111;
      prev_q       <= 3'b111;
      cnt_q        <= '0;
      cursor_col   <= COL_RESET;
      move_valid   <= 1'b0;
      move_col     <= '0;
      reject_pulse <= 1'b0;
      busy         <= 1'b0;
    end else begin
      btn_q        <= {btn_drop, btn_right, btn_left};
      prev_q       <= btn_q;
      cnt_q        <= cnt_d;
      cursor_col   <= cursor_d;
      move_valid   <= move_valid_d;
      move_col     <= move_col_d;
      reject_pulse <= reject_d;
      busy         <= busy_d;
    end
  end

endmodule
